// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg: valid/ready stage register with 2-entry skid buffer and flush.
// Optional perf counters when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid_reg #(
  parameter int PAYLOAD_W = 101,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 Flush_In,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  input  logic [PAYLOAD_W-1:0] In_Data,
  output logic                 Out_Valid,
  input  logic                 Out_Ready,
  output logic [PAYLOAD_W-1:0] Out_Data,
  output logic [1:0]           Occupancy_Out,
  output logic [CNT_W-1:0]     Stall_Cnt_Out,
  output logic [CNT_W-1:0]     Flush_Cnt_Out
);
  logic                 main_v, skid_v;
  logic [PAYLOAD_W-1:0] main_d, skid_d;
  logic                 accept, consume;
  assign In_Ready      = ~skid_v & ~Flush_In;
  assign Out_Valid     = main_v;
  assign Out_Data      = main_d;
  assign Occupancy_Out = {1'b0, main_v} + {1'b0, skid_v};
  assign accept        = In_Valid & In_Ready;
  assign consume       = main_v & Out_Ready;
  // skid_v alone (state 10) falls into the FULL branch, which forces main_v high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
    end else if (Flush_In) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (skid_v) begin
      main_v <= 1'b1;
      if (consume) begin
        skid_v <= 1'b0;
        main_d <= skid_d;
      end
    end else if (main_v) begin
      if (accept && !consume) begin
        skid_v <= 1'b1;
        skid_d <= In_Data;
      end else if (accept) begin
        main_d <= In_Data;
      end else if (consume) begin
        main_v <= 1'b0;
      end
    end else if (accept) begin
      main_v <= 1'b1;
      main_d <= In_Data;
    end
  end
`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (main_v && !Out_Ready && !Flush_In && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (Flush_In && (main_v || skid_v) && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
  assign Stall_Cnt_Out = stall_cnt;
  assign Flush_Cnt_Out = flush_cnt;
`else
  assign Stall_Cnt_Out = '0;
  assign Flush_Cnt_Out = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb_pipe_stage_skid_reg: queue-model checker plus directed vectors for pipe_stage_skid_reg.
module tb_pipe_stage_skid_reg;
  localparam int PW = 101;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          Flush_In = 1'b0;
  logic          In_Valid = 1'b0;
  logic          In_Ready;
  logic [PW-1:0] In_Data = '0;
  logic          Out_Valid;
  logic          Out_Ready = 1'b0;
  logic [PW-1:0] Out_Data;
  logic [1:0]    Occupancy_Out;
  logic [CW-1:0] Stall_Cnt_Out, Flush_Cnt_Out;
  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  logic [PW-1:0] q[$];
  int m_stall = 0;
  int m_flush = 0;
  pipe_stage_skid_reg #(.PAYLOAD_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .Flush_In(Flush_In),
    .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Data(In_Data),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Data(Out_Data),
    .Occupancy_Out(Occupancy_Out), .Stall_Cnt_Out(Stall_Cnt_Out), .Flush_Cnt_Out(Flush_Cnt_Out)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: the stage is a FIFO of depth 2 that refuses input when full or flushing
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_stall = 0;
      m_flush = 0;
    end else begin
      bit acc, con;
      acc = In_Valid && q.size() < 2 && !Flush_In;
      con = q.size() > 0 && Out_Ready;
      if (q.size() > 0 && !Out_Ready && !Flush_In && m_stall < CMAX) m_stall++;
      if (Flush_In && q.size() > 0 && m_flush < CMAX) m_flush++;
      if (Flush_In) q.delete();
      else begin
        if (con) void'(q.pop_front());
        if (acc) q.push_back(In_Data);
      end
    end
    chk_en <= 1'b1;
  end
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_out_valid", Out_Valid, q.size() > 0);
      check("m_in_ready", In_Ready, q.size() < 2 && !Flush_In);
      check("m_occupancy", Occupancy_Out, q.size());
      if (q.size() > 0) check("m_out_data", Out_Data, q[0]);
`ifdef PIPE_STAGE_PERF_EN
      check("m_stall_cnt", Stall_Cnt_Out, m_stall);
      check("m_flush_cnt", Flush_Cnt_Out, m_flush);
`else
      check("m_stall_cnt", Stall_Cnt_Out, 0);
      check("m_flush_cnt", Flush_Cnt_Out, 0);
`endif
    end
  end
  task automatic drive(input bit v, input int d, input bit r, input bit f);
    In_Valid = v;
    In_Data = PW'(d);
    Out_Ready = r;
    Flush_In = f;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_cnt(input string name, input int stall_exp, input int flush_exp);
`ifdef PIPE_STAGE_PERF_EN
    check({name, "_stall"}, Stall_Cnt_Out, stall_exp);
    check({name, "_flush"}, Flush_Cnt_Out, flush_exp);
`else
    check({name, "_stall"}, Stall_Cnt_Out, 0);
    check({name, "_flush"}, Flush_Cnt_Out, 0);
`endif
  endtask
  initial begin
    tick();
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 0);
    check("rst_out_valid", Out_Valid, 0);
    check("rst_out_data", Out_Data, 0);
    check("rst_occ", Occupancy_Out, 0);
    check("rst_in_ready", In_Ready, 1);
    check_cnt("rst", 0, 0);
    for (int i = 1; i <= 4; i++) begin
      drive(1, i, 1, 0);
      check("stream_in_ready", In_Ready, 1);
      tick();
      check("stream_valid", Out_Valid, 1);
      check("stream_data", Out_Data, i);
      check("stream_occ", Occupancy_Out, 1);
    end
    drive(0, 0, 1, 0);
    tick();
    check("stream_drained", Out_Valid, 0);
    drive(1, 'hA, 0, 0);
    tick();
    drive(1, 'hB, 0, 0);
    tick();
    drive(1, 'hC, 0, 0);
    check("bp_occ", Occupancy_Out, 2);
    check("bp_in_ready", In_Ready, 0);
    check("bp_head", Out_Data, 'hA);
    tick();
    check("bp_hold", Out_Data, 'hA);
    check_cnt("bp", 2, 0);
    drive(1, 'hC, 1, 0);
    tick();
    check("bp_second", Out_Data, 'hB);
    check("bp_occ1", Occupancy_Out, 1);
    tick();
    check("bp_third", Out_Data, 'hC);
    drive(0, 0, 1, 0);
    tick();
    check("bp_empty", Occupancy_Out, 0);
    drive(1, 'h10, 0, 0);
    tick();
    drive(1, 'h11, 0, 0);
    tick();
    drive(1, 'h12, 0, 1);
    check("fl_full_occ", Occupancy_Out, 2);
    check("fl_in_ready", In_Ready, 0);
    tick();
    drive(0, 0, 1, 0);
    check("fl_occ", Occupancy_Out, 0);
    check("fl_valid", Out_Valid, 0);
    check_cnt("fl", 3, 1);
    tick();
    drive(0, 0, 0, 1);
    tick();
    check_cnt("fl_empty", 3, 1);
    drive(1, 'h20, 0, 0);
    tick();
    drive(0, 0, 1, 1);
    check("flc_valid", Out_Valid, 1);
    check("flc_data", Out_Data, 'h20);
    tick();
    check("flc_occ", Occupancy_Out, 0);
    check_cnt("flc", 3, 2);
    drive(1, 'h30, 0, 0);
    tick();
    drive(1, 'h31, 0, 0);
    tick();
    check("rm_full", Occupancy_Out, 2);
    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("rm_valid", Out_Valid, 0);
    check("rm_data", Out_Data, 0);
    check("rm_occ", Occupancy_Out, 0);
    check_cnt("rm", 0, 0);
    drive(1, 'h40, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    repeat (20) tick();
    check("sat_valid", Out_Valid, 1);
    check_cnt("sat", 15, 0);
    drive(0, 0, 1, 0);
    tick();
    check("sat_drained", Occupancy_Out, 0);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
